fp_to_int: RTL and testbench

//   Multi-cycle IEEE-754 binary32 -> two's-complement signed integer converter, truncating toward zero.

---
 rtl/fp_pkg.sv | 48 ++++
 rtl/fp_unpack.sv | 58 +++++
 rtl/fp_to_int.sv | 188 ++++++++++++++++++
 tb/tb_fp_to_int.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg
//   Shared definitions for the binary32 -> signed integer converter:
//   field widths, exponent bias, saturation constants, FSM state encoding,
//   operand classification and field-extraction helpers.
package fp_pkg;

  localparam int INT_SIZE      = 32;
  localparam int PRECISION     = 32;
  localparam int EXPONENT_SIZE = 8;
  localparam int MANTISSA_SIZE = 23;
  localparam int EXP_BIAS      = (1 << (EXPONENT_SIZE - 1)) - 1;

  // Significand register carries one spare bit above the integer width.
  localparam int SIG_W = INT_SIZE + 1;
  localparam int CNT_W = 5;

  localparam logic [INT_SIZE-1:0] INT_MAX = {1'b0, {(INT_SIZE-1){1'b1}}};
  localparam logic [INT_SIZE-1:0] INT_MIN = {1'b1, {(INT_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_INF    = 3'd2,
    CLS_NAN    = 3'd3,
    CLS_UNDER  = 3'd4,
    CLS_OVER   = 3'd5,
    CLS_NORMAL = 3'd6
  } fp_class_e;

  function automatic logic fp_sign(input logic [PRECISION-1:0] f);
    return f[PRECISION-1];
  endfunction

  function automatic logic [EXPONENT_SIZE-1:0] fp_exp(input logic [PRECISION-1:0] f);
    return f[PRECISION-2 -: EXPONENT_SIZE];
  endfunction

  function automatic logic [MANTISSA_SIZE-1:0] fp_man(input logic [PRECISION-1:0] f);
    return f[MANTISSA_SIZE-1:0];
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// fp_unpack
//   Combinational front end: splits a binary32 word into its fields,
//   classifies it and derives the shift needed to align the significand
//   with the integer LSB.
// Ports
//   fp          in   operand word
//   sign        out  sign bit
//   man         out  stored fraction
//   cls         out  zero/denorm/inf/nan/underflow/overflow/normal
//   e           out  unbiased exponent (signed)
//   shamt       out  |e - mantissa_size| (meaningful for normal class only)
//   shift_left  out  1 when e > mantissa_size
module fp_unpack
  import fp_pkg::*;
(
  input  logic [PRECISION-1:0]         fp,
  output logic                         sign,
  output logic [MANTISSA_SIZE-1:0]     man,
  output fp_class_e                    cls,
  output logic signed [EXPONENT_SIZE:0] e,
  output logic [CNT_W-1:0]             shamt,
  output logic                         shift_left
);

  localparam logic signed [EXPONENT_SIZE:0] BIAS_S  = EXP_BIAS;
  localparam logic signed [EXPONENT_SIZE:0] MAN_S   = MANTISSA_SIZE;
  localparam logic signed [EXPONENT_SIZE:0] E_MAX_S = INT_SIZE - 1;

  logic [EXPONENT_SIZE-1:0]      exp_f;
  logic signed [EXPONENT_SIZE:0] diff;
  logic signed [EXPONENT_SIZE:0] ndiff;

  always_comb begin
    sign  = fp_sign(fp);
    exp_f = fp_exp(fp);
    man   = fp_man(fp);

    e     = $signed({1'b0, exp_f}) - BIAS_S;
    diff  = e - MAN_S;
    ndiff = -diff;

    shift_left = !diff[EXPONENT_SIZE] && (diff != '0);
    shamt      = shift_left ? diff[CNT_W-1:0] : ndiff[CNT_W-1:0];

    if (exp_f == '0) begin
      cls = (man == '0) ? CLS_ZERO : CLS_DENORM;
    end else if (&exp_f) begin
      cls = (man == '0) ? CLS_INF : CLS_NAN;
    end else if (e[EXPONENT_SIZE]) begin
      cls = CLS_UNDER;
    end else if (e >= E_MAX_S) begin
      cls = CLS_OVER;
    end else begin
      cls = CLS_NORMAL;
    end
  end

endmodule

// File: rtl/fp_to_int.sv
// fp_to_int
//   Multi-cycle binary32 -> two's-complement integer converter, truncating
//   toward zero. The significand is aligned one bit per clock.
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous active-low reset
//   start     in   conversion request, sampled only in IDLE
//   fp        in   operand, captured on the accepting edge
//   int_out   out  integer result, held until the next completion
//                  ("int" is a reserved word in SystemVerilog)
//   done      out  one-cycle completion pulse
//   busy      out  conversion in progress
//   overflow  out  result saturated (Inf, NaN, out of range)
//   inexact   out  nonzero fraction bits were discarded
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | waiting for start; outputs hold last result
// ST_SHIFT  | aligning significand, one bit per clock, cnt counts down
// ST_FINISH | apply sign, publish result and flags, pulse done
module fp_to_int
  import fp_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PRECISION-1:0] fp,
  output logic [INT_SIZE-1:0]  int_out,
  output logic                 done,
  output logic                 busy,
  output logic                 overflow,
  output logic                 inexact
);

  localparam logic signed [EXPONENT_SIZE:0] E_MAX_S = INT_SIZE - 1;

  logic                          u_sign;
  logic [MANTISSA_SIZE-1:0]      u_man;
  fp_class_e                     u_cls;
  logic signed [EXPONENT_SIZE:0] u_e;
  logic [CNT_W-1:0]              u_shamt;
  logic                          u_left;

  fp_unpack u_unpack (
    .fp         (fp),
    .sign       (u_sign),
    .man        (u_man),
    .cls        (u_cls),
    .e          (u_e),
    .shamt      (u_shamt),
    .shift_left (u_left)
  );

  state_e              state_q,    state_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [SIG_W-1:0]    sig_q,      sig_d;
  logic                sign_q,     sign_d;
  logic                left_q,     left_d;
  logic                sticky_q,   sticky_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [INT_SIZE-1:0] int_q,      int_d;
  logic                done_q,     done_d;
  logic                busy_q,     busy_d;
  logic                overflow_q, overflow_d;
  logic                inexact_q,  inexact_d;
  logic [INT_SIZE-1:0] mag;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sig_d      = sig_q;
    sign_d     = sign_q;
    left_d     = left_q;
    sticky_d   = sticky_q;
    ovf_pend_d = ovf_pend_q;
    int_d      = int_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    overflow_d = overflow_q;
    inexact_d  = inexact_q;
    mag        = sig_q[INT_SIZE-1:0];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          sign_d     = u_sign;
          sticky_d   = 1'b0;
          ovf_pend_d = 1'b0;
          cnt_d      = u_shamt;
          left_d     = u_left;
          sig_d      = {{(SIG_W-MANTISSA_SIZE-1){1'b0}}, 1'b1, u_man};
          state_d    = ST_SHIFT;

          // Special cases preload the final magnitude/sign so FINISH can
          // treat every outcome the same way: INT_MIN is -(2^31).
          case (u_cls)
            CLS_ZERO, CLS_DENORM, CLS_UNDER: begin
              sig_d    = '0;
              sticky_d = (u_cls != CLS_ZERO);
              state_d  = ST_FINISH;
            end
            CLS_NAN: begin
              sign_d     = 1'b1;
              sig_d      = {1'b0, INT_MIN};
              ovf_pend_d = 1'b1;
              state_d    = ST_FINISH;
            end
            CLS_INF, CLS_OVER: begin
              if (u_sign) begin
                sig_d      = {1'b0, INT_MIN};
                // -2^31 exactly is representable
                ovf_pend_d = (u_cls == CLS_INF) || (u_e != E_MAX_S) || (u_man != '0);
              end else begin
                sig_d      = {1'b0, INT_MAX};
                ovf_pend_d = 1'b1;
              end
              state_d = ST_FINISH;
            end
            default: ;
          endcase
        end
      end

      ST_SHIFT: begin
        if (cnt_q == '0) begin
          state_d = ST_FINISH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (left_q) begin
            sig_d = sig_q << 1;
          end else begin
            sig_d    = sig_q >> 1;
            sticky_d = sticky_q | sig_q[0];
          end
        end
      end

      ST_FINISH: begin
        int_d      = sign_q ? -mag : mag;
        overflow_d = ovf_pend_q | sig_q[SIG_W-1];
        inexact_d  = sticky_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sig_q      <= '0;
      sign_q     <= 1'b0;
      left_q     <= 1'b0;
      sticky_q   <= 1'b0;
      ovf_pend_q <= 1'b0;
      int_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      inexact_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sig_q      <= sig_d;
      sign_q     <= sign_d;
      left_q     <= left_d;
      sticky_q   <= sticky_d;
      ovf_pend_q <= ovf_pend_d;
      int_q      <= int_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      inexact_q  <= inexact_d;
    end
  end

  assign int_out  = int_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign inexact  = inexact_q;

endmodule

// File: tb/tb_fp_to_int.sv
// tb_fp_to_int
//   Self-checking bench for fp_to_int: directed vectors with hand-derived
//   results, handshake/reset scenarios, and randomized operands checked
//   against a real-arithmetic reference model.
module tb_fp_to_int;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] fp;
  logic [31:0] int_out;
  logic        done;
  logic        busy;
  logic        overflow;
  logic        inexact;

  int n_checks = 0;
  int n_errors = 0;

  fp_to_int dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .fp       (fp),
    .int_out  (int_out),
    .done     (done),
    .busy     (busy),
    .overflow (overflow),
    .inexact  (inexact)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: value = 1.m * 2^e as a real, truncated with $rtoi,
  // saturated to the 32-bit range. Latency from the accepting edge.
  task automatic model(input logic [31:0] f, output logic [31:0] res,
                       output logic ovf, output logic inx, output int lat);
    int  ex, e, iv;
    real mag, r;
    ex  = int'(f[30:23]);
    e   = ex - 127;
    res = '0;
    ovf = 1'b0;
    inx = 1'b0;
    if (ex == 0 || ex == 255 || e < 0 || e > 30) lat = 1;
    else lat = ((e > 23) ? e - 23 : 23 - e) + 2;
    if (ex == 255) begin
      ovf = 1'b1;
      res = (f[22:0] == '0 && !f[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
    end else if (ex == 0) begin
      inx = (f[22:0] != '0);
    end else begin
      mag = real'({8'd0, 1'b1, f[22:0]});
      if (e >= 23) for (int i = 0; i < e - 23; i++) mag = mag * 2.0;
      else         for (int i = 0; i < 23 - e; i++) mag = mag / 2.0;
      r = f[31] ? -mag : mag;
      if (r >= 2147483648.0) begin
        res = 32'h7FFF_FFFF;
        ovf = 1'b1;
      end else if (r < -2147483648.0) begin
        res = 32'h8000_0000;
        ovf = 1'b1;
      end else begin
        iv  = $rtoi(r);
        res = 32'(iv);
        inx = (real'(iv) != r);
      end
    end
  endtask

  // Called one time unit after a posedge with the DUT idle.
  task automatic convert(input logic [31:0] f, input logic [31:0] er,
                         input logic eo, input logic ei, input int el, input string tag);
    int n;
    bit seen;
    fp    = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fp    = $urandom();
    check({tag, "/busy_on"}, 32'(busy), 32'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
    end
    check({tag, "/done_seen"}, 32'(seen), 32'd1);
    check({tag, "/latency"}, 32'(n), 32'(el));
    check({tag, "/int"}, int_out, er);
    check({tag, "/overflow"}, 32'(overflow), 32'(eo));
    check({tag, "/inexact"}, 32'(inexact), 32'(ei));
    check({tag, "/busy_off"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "/done_drop"}, 32'(done), 32'd0);
    check({tag, "/int_hold"}, int_out, er);
  endtask

  typedef struct {
    logic [31:0] f;
    logic [31:0] r;
    logic        o;
    logic        x;
    int          lat;
  } vec_t;

  vec_t vecs[$] = '{
    '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 25},
    '{32'hC2F6_E979, 32'hFFFF_FF85, 1'b0, 1'b1, 19},
    '{32'h4B7F_FFFF, 32'h00FF_FFFF, 1'b0, 1'b0,  2},
    '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0,  1},
    '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0,  1},
    '{32'h7FC0_0000, 32'h8000_0000, 1'b1, 1'b0,  1},
    '{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1,  1},
    '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1,  1},
    '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0,  1},
    '{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0,  1},
    '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0,  1},
    '{32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0,  1},
    '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0,  9},
    '{32'hCEFF_FFFF, 32'h8000_0080, 1'b0, 1'b0,  9},
    '{32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b1, 25},
    '{32'hBFC0_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 25}
  };

  initial begin
    logic [31:0] f, er;
    logic        eo, ei;
    int          el, dcnt, n;
    bit          seen;
    logic [31:0] last_int;

    reset = 1'b0;
    start = 1'b0;
    fp    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/int", int_out, 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/overflow", 32'(overflow), 32'd0);
    check("rst/inexact", 32'(inexact), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      convert(vecs[i].f, vecs[i].r, vecs[i].o, vecs[i].x, vecs[i].lat, $sformatf("dir%0d", i));

    // start pulsed during SHIFT must be ignored
    fp    = 32'h3F80_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    fp    = 32'h4F00_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dcnt     = 0;
    last_int = '0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done) begin
        dcnt++;
        last_int = int_out;
      end
    end
    check("ignore/done_count", 32'(dcnt), 32'd1);
    check("ignore/int", last_int, 32'd1);
    check("ignore/overflow", 32'(overflow), 32'd0);

    // reset in the middle of SHIFT aborts without a done pulse
    fp    = 32'hC2F6_E979;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/int", int_out, 32'd0);
    check("abort/done", 32'(done), 32'd0);
    reset = 1'b1;
    dcnt  = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("abort/no_done", 32'(dcnt), 32'd0);

    // start held through done: second conversion accepted on the done edge
    fp    = 32'h4B7F_FFFF;
    start = 1'b1;
    @(posedge clk); #1;
    fp = 32'hC2F6_E979;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b/done1", 32'(done), 32'd1);
    check("b2b/int1", int_out, 32'h00FF_FFFF);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b/busy2", 32'(busy), 32'd1);
    check("b2b/done_drop", 32'(done), 32'd0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
    end
    check("b2b/done2_seen", 32'(seen), 32'd1);
    check("b2b/latency2", 32'(n), 32'd19);
    check("b2b/int2", int_out, 32'hFFFF_FF85);
    check("b2b/inexact2", 32'(inexact), 32'd1);
    @(posedge clk); #1;

    // randomized operands, biased toward the interesting exponent range
    for (int k = 0; k < 1500; k++) begin
      int sel;
      f   = $urandom();
      sel = $urandom_range(0, 9);
      if (sel < 7)       f[30:23] = 8'($urandom_range(115, 160));
      else if (sel == 7) f[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      model(f, er, eo, ei, el);
      convert(f, er, eo, ei, el, $sformatf("rnd%0d_%h", k, f));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
